// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and defaults for the universal shift register
package usr_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SHIFT_R = 2'd1,
    SHIFT_L = 2'd2,
    LOAD    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_LANES = 1;

endpackage

// File: rtl/usr_word_cnt.sv
// rtl/usr_word_cnt.sv - modulo-DEPTH shift counter producing the word capture strobe
module usr_word_cnt #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  input  logic clear,
  output logic wrap
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [CW-1:0] cnt;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign wrap = en && shift && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clear) begin
        cnt <= '0;
      end else if (shift) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-lane hold/shift/load register with word capture
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [LANES-1:0]       si,
  input  logic [DEPTH*LANES-1:0] pin,
  output logic [LANES-1:0]       out,
  output logic [DEPTH*LANES-1:0] q,
  output logic [DEPTH*LANES-1:0] word_out,
  output logic                   word_valid
);

  logic [DEPTH*LANES-1:0] q_next;
  dir_t                   dir;
  dir_t                   dir_next;
  logic                   shift;
  logic                   load;
  logic                   wrap;

  // Stage i occupies q[i*LANES +: LANES]; right shifts move toward higher stages.
  always_comb begin
    q_next   = q;
    dir_next = dir;
    shift    = 1'b0;
    load     = 1'b0;
    case (mode_t'(mode))
      SHIFT_R: begin
        q_next   = {q[(DEPTH-1)*LANES-1:0], si};
        dir_next = DIR_R;
        shift    = 1'b1;
      end
      SHIFT_L: begin
        q_next   = {si, q[DEPTH*LANES-1:LANES]};
        dir_next = DIR_L;
        shift    = 1'b1;
      end
      LOAD: begin
        q_next = pin;
        load   = 1'b1;
      end
      default: ;
    endcase
  end

  usr_word_cnt #(.DEPTH(DEPTH)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .shift (shift),
    .clear (load),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      dir        <= DIR_R;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (en) begin
      q          <= q_next;
      dir        <= dir_next;
      word_valid <= wrap;
      if (wrap) begin
        word_out <= q_next;
      end
    end else begin
      word_valid <= 1'b0;
    end
  end

  assign out = (dir == DIR_R) ? q[DEPTH*LANES-1 -: LANES] : q[LANES-1:0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - table-driven scoreboard bench for universal_shift_reg
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int DEPTH = 4;
  localparam int LANES = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [1:0]             mode;
  logic [LANES-1:0]       si;
  logic [DEPTH*LANES-1:0] pin;
  logic [LANES-1:0]       out;
  logic [DEPTH*LANES-1:0] q;
  logic [DEPTH*LANES-1:0] word_out;
  logic                   word_valid;

  always #5 clk = ~clk;

  universal_shift_reg #(.DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .si         (si),
    .pin        (pin),
    .out        (out),
    .q          (q),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] m;
    logic       s;
    logic [3:0] p;
    logic [3:0] eq;
    logic       eo;
    logic       ev;
    logic [3:0] ew;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       o;
    logic       v;
    logic [3:0] w;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic s,
                      input logic [3:0] p, input logic [3:0] eq, input logic eo,
                      input logic ev, input logic [3:0] ew, input string tag);
    exp_t x;
    rst  = r;
    en   = e;
    mode = m;
    si   = s;
    pin  = p;
    x.q = eq; x.o = eo; x.v = ev; x.w = ew; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, " q"}, q, x.q);
    check({x.tag, " out"}, {3'b000, out}, {3'b000, x.o});
    check({x.tag, " word_valid"}, {3'b000, word_valid}, {3'b000, x.v});
    check({x.tag, " word_out"}, word_out, x.w);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = HOLD; si = 1'b0; pin = '0;
    @(posedge clk);
    #1;

    // reset with si toggling and mode=SHIFT_R
    tbl.push_back('{1'b1, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b1, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000});
    // SIPO/SISO right
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b1011, 1'b1, 1'b1, 4'b1011});
    tbl.push_back('{1'b0, 1'b1, HOLD,    1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b1011});
    // PISO
    tbl.push_back('{1'b0, 1'b1, LOAD,    1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b1011});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b0, 4'b1011});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1011});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1011});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000});
    // shift left
    tbl.push_back('{1'b0, 1'b1, LOAD,    1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_L, 1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_L, 1'b1, 4'b0000, 4'b1110, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_L, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000});
    // LOAD keeps dir left, clears the count; then enable/hold
    tbl.push_back('{1'b0, 1'b1, LOAD,    1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 1'b0, SHIFT_R, 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < 2; i++)
      tbl.push_back('{1'b0, 1'b1, HOLD, 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b1, 4'b1110});
    tbl.push_back('{1'b0, 1'b0, SHIFT_R, 1'b1, 4'b0000, 4'b1110, 1'b1, 1'b0, 4'b1110});

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].p,
           tbl[i].eq, tbl[i].eo, tbl[i].ev, tbl[i].ew, $sformatf("vec%0d", i));

    // mid-word LOAD discards the partial count
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b1101, 1'b1, 1'b0, 4'b1110, "lda0");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b1110, "lda1");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 4'b1110, "lda2");
    step(1'b0, 1'b1, LOAD,    1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0, 4'b1110, "lda_load");
    step(1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b1010, 1'b1, 1'b0, 4'b1110, "lda3");
    step(1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b1110, "lda4");
    step(1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1110, "lda5");
    step(1'b0, 1'b1, SHIFT_R, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, "lda6");

    // mid-word reset behaves the same and clears q
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, "rsa0");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "rsa1");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 4'b0000, "rsa2");
    step(1'b1, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, "rsa_rst");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, "rsa3");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "rsa4");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 4'b0000, "rsa5");
    step(1'b0, 1'b1, SHIFT_R, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111, "rsa6");
    step(1'b0, 1'b1, HOLD,    1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111, "rsa7");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
